// File: rtl/nlp_pkg.sv
// Shared definitions for the next-N-line prefetcher.
//   state_t       : prefetch sequencer states
//   offset_w()    : byte-offset width of a cache line
//   line_w()      : width of a line address within a 32-bit byte address
//   line_of()     : byte address -> line address (right-aligned)
//   line_to_addr(): line address -> line-aligned byte address
package nlp_pkg;

    localparam int unsigned ADDR_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_REQ   = 2'd2
    } state_t;

    function automatic int unsigned offset_w(input int unsigned block_bytes);
        return $clog2(block_bytes);
    endfunction

    function automatic int unsigned line_w(input int unsigned block_bytes);
        return ADDR_W - $clog2(block_bytes);
    endfunction

    function automatic logic [ADDR_W-1:0] line_of(input logic [ADDR_W-1:0] a,
                                                  input int unsigned      ow);
        return a >> ow;
    endfunction

    function automatic logic [ADDR_W-1:0] line_to_addr(input logic [ADDR_W-1:0] l,
                                                       input int unsigned      ow);
        return l << ow;
    endfunction

endpackage

// File: rtl/nline_prefetcher_pf_buffer.sv
// Fully associative prefetch buffer with FIFO replacement.
//   clk, rst_n      : clock, synchronous active-low reset (clears valids and pointer)
//   i_lookup_en     : demand-miss lookup strobe
//   i_lookup_line   : demand line address
//   o_lookup_hit    : lookup matched a valid entry (pre-edge contents)
//   i_cand_line     : sequencer candidate line
//   o_cand_hit      : candidate already held in a valid entry
//   i_ins_en        : insert strobe (accepted prefetch request)
//   i_ins_line      : line address to insert at the write pointer
module pf_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned LINE_W = 28
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_lookup_en,
    input  logic [LINE_W-1:0] i_lookup_line,
    output logic              o_lookup_hit,
    input  logic [LINE_W-1:0] i_cand_line,
    output logic              o_cand_hit,
    input  logic              i_ins_en,
    input  logic [LINE_W-1:0] i_ins_line
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [LINE_W-1:0] r_line [DEPTH];
    logic [DEPTH-1:0]  r_valid;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [DEPTH-1:0]  w_lookup_match;
    logic [DEPTH-1:0]  w_cand_match;

    always_comb begin
        w_lookup_match = '0;
        w_cand_match   = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            w_lookup_match[i] = r_valid[i] && (r_line[i] == i_lookup_line);
            w_cand_match[i]   = r_valid[i] && (r_line[i] == i_cand_line);
        end
    end

    assign o_lookup_hit = i_lookup_en && (|w_lookup_match);
    assign o_cand_hit   = |w_cand_match;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid  <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (i_lookup_en) begin
                r_valid <= r_valid & ~w_lookup_match;
            end
            // Placed after the invalidate so an insert into the same slot wins.
            if (i_ins_en) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_line[r_wr_ptr]  <= i_ins_line;
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/nline_prefetcher.sv
// Next-N-line prefetcher: looks up each demand miss in the prefetch buffer and
// issues up to DEGREE sequential line requests over a valid/ready handshake.
//   clk, rst_n    : clock, synchronous active-low reset
//   enable        : allows new sequences to start or be queued
//   address       : demand byte address
//   cache_miss    : demand miss strobe
//   prefetch_hit  : registered lookup result
//   pf_req_valid  : request valid, held until pf_req_ready
//   pf_req_ready  : next level accepts the request
//   pf_req_addr   : line-aligned request address
//   busy          : sequencer not idle
//   hit_count     : saturating buffer-hit counter
//   issue_count   : saturating accepted-request counter
module nline_prefetcher
    import nlp_pkg::*;
#(
    parameter int unsigned BLOCK_SIZE_BYTE = 16,
    parameter int unsigned PB_DEPTH        = 4,
    parameter int unsigned DEGREE          = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [31:0] address,
    input  logic        cache_miss,
    output logic        prefetch_hit,
    output logic        pf_req_valid,
    input  logic        pf_req_ready,
    output logic [31:0] pf_req_addr,
    output logic        busy,
    output logic [31:0] hit_count,
    output logic [31:0] issue_count
);

    localparam int unsigned OFFSET_W = offset_w(BLOCK_SIZE_BYTE);
    localparam int unsigned LINE_W   = line_w(BLOCK_SIZE_BYTE);
    localparam int unsigned K_W      = $clog2(DEGREE + 1);

    state_t            r_state;
    logic [LINE_W-1:0] r_base;
    logic [K_W-1:0]    r_k;
    logic              r_pend;
    logic [LINE_W-1:0] r_pend_base;
    logic              r_req_valid;
    logic [31:0]       r_req_addr;
    logic              r_hit;
    logic [31:0]       r_hit_count;
    logic [31:0]       r_issue_count;

    logic [LINE_W-1:0] w_miss_line;
    logic [LINE_W-1:0] w_cand_line;
    logic [LINE_W-1:0] w_ins_line;
    logic              w_lookup_hit;
    logic              w_cand_hit;
    logic              w_accept;
    logic              w_capture;
    logic              w_advance;

    assign w_miss_line = LINE_W'(line_of(address, OFFSET_W));
    // Natural LINE_W-bit overflow gives the required wrap to line 0.
    assign w_cand_line = r_base + LINE_W'(r_k);
    assign w_ins_line  = LINE_W'(line_of(r_req_addr, OFFSET_W));
    assign w_accept    = r_req_valid && pf_req_ready;
    assign w_capture   = cache_miss && enable;
    assign w_advance   = ((r_state == ST_CHECK) && w_cand_hit) ||
                         ((r_state == ST_REQ) && w_accept);

    pf_buffer #(
        .DEPTH  (PB_DEPTH),
        .LINE_W (LINE_W)
    ) u_pb (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_lookup_en   (cache_miss),
        .i_lookup_line (w_miss_line),
        .o_lookup_hit  (w_lookup_hit),
        .i_cand_line   (w_cand_line),
        .o_cand_hit    (w_cand_hit),
        .i_ins_en      (w_accept),
        .i_ins_line    (w_ins_line)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_k           <= K_W'(1);
            r_pend        <= 1'b0;
            r_req_valid   <= 1'b0;
            r_req_addr    <= '0;
            r_hit         <= 1'b0;
            r_hit_count   <= '0;
            r_issue_count <= '0;
        end else begin
            r_hit <= w_lookup_hit;
            if (w_lookup_hit && (r_hit_count != '1)) begin
                r_hit_count <= r_hit_count + 1'b1;
            end
            if (w_accept && (r_issue_count != '1)) begin
                r_issue_count <= r_issue_count + 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_capture) begin
                        r_base  <= w_miss_line;
                        r_k     <= K_W'(1);
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (!w_cand_hit) begin
                        r_req_addr  <= line_to_addr(32'(w_cand_line), OFFSET_W);
                        r_req_valid <= 1'b1;
                        r_state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (w_accept) begin
                        r_req_valid <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // A queued miss takes priority over continuing the current run.
            if (w_advance) begin
                if (r_pend) begin
                    r_base  <= r_pend_base;
                    r_k     <= K_W'(1);
                    r_pend  <= 1'b0;
                    r_state <= ST_CHECK;
                end else if (r_k == K_W'(DEGREE)) begin
                    r_state <= ST_IDLE;
                end else begin
                    r_k     <= r_k + 1'b1;
                    r_state <= ST_CHECK;
                end
            end

            // Capture after the advance so a miss on the same edge is not lost.
            if ((r_state != ST_IDLE) && w_capture) begin
                r_pend      <= 1'b1;
                r_pend_base <= w_miss_line;
            end
        end
    end

    assign prefetch_hit = r_hit;
    assign pf_req_valid = r_req_valid;
    assign pf_req_addr  = r_req_addr;
    assign busy         = (r_state != ST_IDLE);
    assign hit_count    = r_hit_count;
    assign issue_count  = r_issue_count;

endmodule

// File: doc/nline_prefetcher.md
# nline_prefetcher

- Parametrised next-N-line prefetcher with a fully associative prefetch buffer (PB).
- Sits beside the L1 model in the cache simulator:
  - each demand miss is looked up in the PB and reported as a prefetch hit or not;
  - a miss then triggers up to DEGREE sequential line requests to the next level, using a valid/ready handshake.
- Generalises the single-line prefetcher with configurable depth and degree, duplicate suppression, FIFO replacement, miss queuing and statistics counters.

## Interface
Parameters:
- BLOCK_SIZE_BYTE, 16, line size in bytes (power of 2); OFFSET_W = log2(BLOCK_SIZE_BYTE), LINE_W = 32-OFFSET_W
- PB_DEPTH, 4, prefetch buffer entries (≥1), each holding LINE_W line address + valid
- DEGREE, 2, lines prefetched ahead per miss (≥1)

Ports (reset is synchronous, active-low):
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous active-low reset
- enable  in  1  permits starting/queuing prefetch sequences
- address  in  32  demand byte address
- cache_miss  in  1  demand miss, sampled each edge
- prefetch_hit  out  1  registered lookup result
- pf_req_valid  out  1  prefetch request valid (registered)
- pf_req_ready  in  1  next level accepts request
- pf_req_addr  out  32  line-aligned request address, low OFFSET_W bits zero
- busy  out  1  state ≠ IDLE
- hit_count  out  32  saturating PB hit counter
- issue_count  out  32  saturating accepted-request counter

## Operation
- Line address: L(a) = a[31:OFFSET_W]. Candidate = base + k, modulo 2^LINE_W (wraps to 0).
- Lookup, in any state: on an edge with cache_miss=1:
  - prefetch_hit <= 1 if L(address) matches a valid entry, else 0; prefetch_hit is 0 on edges without a miss;
  - on a hit, the matching entry is invalidated and hit_count increments.
  - Lookup uses pre-edge PB contents; a line inserted on the same edge is not hit.
- Insert: on pf_req_valid && pf_req_ready:
  - entry[wr_ptr] <= {valid, candidate};
  - wr_ptr <= (wr_ptr == PB_DEPTH-1) ? 0 : wr_ptr+1 (FIFO replacement, overwrites regardless of valid);
  - issue_count increments.
  - If invalidate and insert target the same slot on one edge, insert wins.
- FSM states: IDLE, CHECK, REQ.
  - IDLE: cache_miss && enable → base <= L(address), k <= 1, go to CHECK.
  - CHECK: if the candidate is valid in the PB (pre-edge state), skip and ADVANCE. Otherwise pf_req_addr <= {candidate, 0}, pf_req_valid <= 1, go to REQ.
  - REQ: hold pf_req_valid and pf_req_addr stable until accepted (never withdrawn). On acceptance: pf_req_valid <= 0, insert, ADVANCE.
  - ADVANCE:
    - if pend: base <= pend_base, k <= 1, pend <= 0, go to CHECK;
    - else if k == DEGREE: go to IDLE;
    - else k <= k+1, go to CHECK.
- Miss queuing: in CHECK or REQ, cache_miss && enable sets pend <= 1 and pend_base <= L(address). The newest miss overwrites any older pending one. The sequence in flight finishes its current step before the restart.
- enable=0: no new sequence starts and no pend capture. A running sequence completes; lookups and hit counting continue.
- Counters saturate at 0xFFFF_FFFF.

## Timing
- Reset (rst_n=0 at an edge) clears:
  - all valid bits;
  - wr_ptr=0, state=IDLE, pend=0, k=1;
  - prefetch_hit=0, pf_req_valid=0, pf_req_addr=0, busy=0, hit_count=0, issue_count=0.
- Reset mid-REQ drops the request immediately (pf_req_valid=0 after the edge).
- Miss sampled at edge t:
  - prefetch_hit valid after edge t;
  - busy=1 after edge t;
  - first pf_req_valid=1 after edge t+1 (CHECK during t..t+1) if the line is not already present.
- With pf_req_ready=1 constantly: one request every 2 cycles, and an accepted request occupies 2 cycles. A skip costs 1 cycle (one CHECK).
- Sequence of DEGREE issued lines, no stall: busy falls after edge t+2·DEGREE.

## Structure
- Shared package nlp_pkg:
  - FSM state enum;
  - OFFSET_W/LINE_W derivation;
  - line-address extract and rebuild helpers.
- Sub-module pf_buffer:
  - PB storage;
  - parallel compare with two match ports (lookup and candidate check);
  - invalidate-on-hit;
  - FIFO insert pointer with wrap.
- Top-level holds the FSM, pend register and counters.

## Test plan
Settings: BLOCK=16, DEPTH=4, DEGREE=2.
1. Reset, then miss 0x0000_1004 with ready=1 → requests 0x0000_1010 then 0x0000_1020; prefetch_hit=0; issue_count=2; busy low after edge t+4.
2. Then miss 0x0000_1018 → prefetch_hit=1 one edge later; hit_count=1; 0x101 invalidated; 0x102 present, so skipped; only 0x0000_1030 is requested.
3. Miss 0x0000_3000, ready=0 for 5 cycles:
   - pf_req_valid=1 and pf_req_addr=0x0000_3010 stay stable throughout;
   - miss 0x0000_2000 arrives during the stall;
   - after acceptance → requests 0x0000_2010, 0x0000_2020; 0x3020 is never requested.
4. Miss 0xFFFF_FFF4 → requests 0x0000_0000 then 0x0000_0010 (line wrap).
5. FIFO eviction:
   - three non-overlapping sequences (six lines) into PB_DEPTH=4 → first two lines evicted;
   - miss on the first line → prefetch_hit=0; miss on the third line → prefetch_hit=1.
6. Reset and enable:
   - rst_n=0 during REQ → pf_req_valid=0 and counters=0 after the edge; a later miss on a previously buffered line gives prefetch_hit=0;
   - enable=0 with a miss → no request and busy=0.
